washer_main_controller: RTL and testbench

- Top-level washing-machine cycle controller.
- Sequences the wash cycle: mode/option selection, fill, heat, wash, drain, rinse fill, rinse, final drain, spin, complete.
- Drives the valve, heater, pump, drum motor, door lock and status LEDs from sensor inputs.
- Contains the FSM, a phase timer, the temperature selector and the spin-speed selector.

---
 rtl/washer_main_controller.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_washer_main_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/washer_main_controller.sv
// -----------------------------------------------------------------------------
// washer_main_controller
//
// Purpose:
//   Top-level washing-machine cycle controller. One FSM sequences selection,
//   fill, heat, wash, drain, rinse fill, rinse, final drain, spin and complete.
//   It also holds the phase timer, the temperature selector and the spin-speed
//   selector. All actuator/LED outputs are registered and decoded from the
//   next state, so they change on the same edge as the state register.
//
// Optional feature (compile-time macro):
//   EXTRA_RINSE_EN - heavy mode (2) performs a second rinse pass
//                    (FILL_RINSE/RINSE/DRAIN_RINSE) before SPIN.
//
// Ports:
//   clk                     system clock, rising edge
//   reset                   asynchronous active-low reset
//   start, stop, pause      user requests (stop aborts from any state)
//   continue_signal         resume from PAUSED / VIB_HOLD
//   door_locked             latch sensor, 1 = locked
//   clothes_loaded          clothes present
//   load_weight[7:0]        selects fill target (300 below 80, else 800)
//   vibration_sensor        1 = excessive vibration
//   temperature_adc_sensor  water temperature in degC
//   wash_mode[2:0]          0 normal, 1 delicate, 2 heavy, 3 quick, 4-7 normal
//   confirm_wash_mode       accept the selection in START
//   change_temperature      rising edge steps the temperature setting
//   change_spin_speed       rising edge steps the spin level
//   water_level_sensor[9:0] water level
//   cycle_complete_led, door_lock, water_valve, heater, drain_pump,
//   drum_motor[3:0], water_flow_error_led, drainage_error_led,
//   vibration_error_led     registered actuator / LED outputs
//   o_dbg_state[3:0]        current FSM state encoding
//   o_dbg_timer[7:0]        current phase timer value
//
// Inputs are plain levels sampled every clock; there is no valid/ready
// handshake on this block. Only change_temperature/change_spin_speed are
// edge-detected.
// -----------------------------------------------------------------------------
module washer_main_controller #(
    parameter int WASH_TIME     = 20,
    parameter int RINSE_TIME    = 10,
    parameter int SPIN_TIME     = 10,
    parameter int FILL_TIMEOUT  = 30,
    parameter int DRAIN_TIMEOUT = 30,
    parameter int EMPTY_LEVEL   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       continue_signal,
    input  logic       door_locked,
    input  logic       clothes_loaded,
    input  logic [7:0] load_weight,
    input  logic       vibration_sensor,
    input  logic [6:0] temperature_adc_sensor,
    input  logic [2:0] wash_mode,
    input  logic       confirm_wash_mode,
    input  logic       change_temperature,
    input  logic       change_spin_speed,
    input  logic [9:0] water_level_sensor,
    output logic       cycle_complete_led,
    output logic       door_lock,
    output logic       water_valve,
    output logic       heater,
    output logic       drain_pump,
    output logic [3:0] drum_motor,
    output logic       water_flow_error_led,
    output logic       drainage_error_led,
    output logic       vibration_error_led,
    output logic [3:0] o_dbg_state,
    output logic [7:0] o_dbg_timer
);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_START        = 4'd1,
        S_FILL_INITIAL = 4'd2,
        S_HEAT         = 4'd3,
        S_WASH         = 4'd4,
        S_DRAIN_WASH   = 4'd5,
        S_FILL_RINSE   = 4'd6,
        S_RINSE        = 4'd7,
        S_DRAIN_RINSE  = 4'd8,
        S_SPIN         = 4'd9,
        S_COMPLETE     = 4'd10,
        S_PAUSED       = 4'd11,
        S_VIB_HOLD     = 4'd12,
        S_ERROR        = 4'd13
    } state_t;

    // Last timer value of each phase: a phase of N cycles sees timer 0..N-1.
    localparam logic [7:0] WASH_LAST  = 8'(WASH_TIME - 1);
    localparam logic [7:0] QUICK_LAST = 8'((WASH_TIME / 2) - 1);
    localparam logic [7:0] RINSE_LAST = 8'(RINSE_TIME - 1);
    localparam logic [7:0] SPIN_LAST  = 8'(SPIN_TIME - 1);
    localparam logic [7:0] FILL_LAST  = 8'(FILL_TIMEOUT - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);
    localparam logic [9:0] EMPTY_LVL  = 10'(EMPTY_LEVEL);

    state_t     r_state;
    state_t     r_saved;        // state to return to from PAUSED / VIB_HOLD
    logic [7:0] r_timer;
    logic [1:0] r_temp_idx;
    logic [1:0] r_spin_lvl;
    logic [1:0] r_mode;         // wash_mode with 4-7 folded onto normal
    logic       r_sel_seen;     // a change pulse was seen since START entry
    logic       r_chg_temp_d;
    logic       r_chg_spin_d;
`ifdef EXTRA_RINSE_EN
    logic       r_rinse_pass;
`endif

    state_t     w_next;
    logic       w_flow_err;
    logic       w_drain_err;
    logic       w_active;
    logic       w_vib_state;
    logic       w_hold_next;
    logic       w_resume;
    logic       w_level_full;
    logic       w_level_empty;
    logic [9:0] w_fill_target;
    logic [6:0] w_sel_temp;
    logic [7:0] w_wash_last;
    logic [1:0] w_base_temp;
    logic [1:0] w_base_spin;
    logic       w_temp_rise;
    logic       w_spin_rise;

    function automatic logic [1:0] default_temp(input logic [2:0] mode);
        case (mode)
            3'd1:    default_temp = 2'd1;
            3'd2:    default_temp = 2'd3;
            3'd3:    default_temp = 2'd1;
            default: default_temp = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] default_spin(input logic [2:0] mode);
        case (mode)
            3'd1:    default_spin = 2'd1;
            3'd2:    default_spin = 2'd3;
            default: default_spin = 2'd2;
        endcase
    endfunction

    function automatic logic [6:0] temp_of(input logic [1:0] idx);
        case (idx)
            2'd0:    temp_of = 7'd20;
            2'd1:    temp_of = 7'd30;
            2'd2:    temp_of = 7'd40;
            default: temp_of = 7'd60;
        endcase
    endfunction

    always_comb begin
        w_fill_target = (load_weight < 8'd80) ? 10'd300 : 10'd800;
        w_level_full  = (water_level_sensor >= w_fill_target);
        w_level_empty = (water_level_sensor < EMPTY_LVL);
        w_sel_temp    = temp_of(r_temp_idx);
        w_wash_last   = (r_mode == 2'd3) ? QUICK_LAST : WASH_LAST;
        w_active      = (r_state >= S_FILL_INITIAL) && (r_state <= S_SPIN);
        w_vib_state   = (r_state == S_WASH) || (r_state == S_RINSE) ||
                        (r_state == S_SPIN);

        // Until the user touches a selector, both follow wash_mode live.
        w_base_temp   = r_sel_seen ? r_temp_idx : default_temp(wash_mode);
        w_base_spin   = r_sel_seen ? r_spin_lvl : default_spin(wash_mode);
        w_temp_rise   = change_temperature & ~r_chg_temp_d;
        w_spin_rise   = change_spin_speed & ~r_chg_spin_d;

        w_next      = r_state;
        w_flow_err  = 1'b0;
        w_drain_err = 1'b0;

        // Priority: stop > vibration > pause > normal transition.
        if (stop) begin
            w_next = S_IDLE;
        end else if (w_vib_state && vibration_sensor) begin
            w_next = S_VIB_HOLD;
        end else if (w_active && pause) begin
            w_next = S_PAUSED;
        end else begin
            case (r_state)
                S_IDLE:
                    if (start && clothes_loaded && door_locked) w_next = S_START;
                S_START:
                    if (confirm_wash_mode) w_next = S_FILL_INITIAL;
                S_FILL_INITIAL:
                    if (w_level_full) begin
                        w_next = S_HEAT;
                    end else if (r_timer >= FILL_LAST) begin
                        w_next     = S_ERROR;
                        w_flow_err = 1'b1;
                    end
                S_HEAT:
                    if (temperature_adc_sensor >= w_sel_temp) w_next = S_WASH;
                S_WASH:
                    if (r_timer >= w_wash_last) w_next = S_DRAIN_WASH;
                S_DRAIN_WASH:
                    if (w_level_empty) begin
                        w_next = S_FILL_RINSE;
                    end else if (r_timer >= DRAIN_LAST) begin
                        w_next      = S_ERROR;
                        w_drain_err = 1'b1;
                    end
                S_FILL_RINSE:
                    if (w_level_full) begin
                        w_next = S_RINSE;
                    end else if (r_timer >= FILL_LAST) begin
                        w_next     = S_ERROR;
                        w_flow_err = 1'b1;
                    end
                S_RINSE:
                    if (r_timer >= RINSE_LAST) w_next = S_DRAIN_RINSE;
                S_DRAIN_RINSE:
                    if (w_level_empty) begin
`ifdef EXTRA_RINSE_EN
                        if ((r_mode == 2'd2) && !r_rinse_pass) w_next = S_FILL_RINSE;
                        else                                   w_next = S_SPIN;
`else
                        w_next = S_SPIN;
`endif
                    end else if (r_timer >= DRAIN_LAST) begin
                        w_next      = S_ERROR;
                        w_drain_err = 1'b1;
                    end
                S_SPIN:
                    if (r_timer >= SPIN_LAST) w_next = S_COMPLETE;
                S_COMPLETE:
                    if (!door_locked || start) w_next = S_IDLE;
                S_PAUSED:
                    if (continue_signal) w_next = r_saved;
                S_VIB_HOLD:
                    if (continue_signal && !vibration_sensor) w_next = r_saved;
                S_ERROR:
                    w_next = S_ERROR;
                default:
                    w_next = S_IDLE;
            endcase
        end

        w_hold_next = (w_next == S_PAUSED) || (w_next == S_VIB_HOLD);
        // Leaving a hold state for anything but IDLE is always a resume.
        w_resume    = ((r_state == S_PAUSED) || (r_state == S_VIB_HOLD)) &&
                      (w_next != S_IDLE) && !w_hold_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state              <= S_IDLE;
            r_saved              <= S_IDLE;
            r_timer              <= 8'd0;
            r_temp_idx           <= 2'd2;
            r_spin_lvl           <= 2'd2;
            r_mode               <= 2'd0;
            r_sel_seen           <= 1'b0;
            r_chg_temp_d         <= 1'b0;
            r_chg_spin_d         <= 1'b0;
`ifdef EXTRA_RINSE_EN
            r_rinse_pass         <= 1'b0;
`endif
            cycle_complete_led   <= 1'b0;
            door_lock            <= 1'b0;
            water_valve          <= 1'b0;
            heater               <= 1'b0;
            drain_pump           <= 1'b0;
            drum_motor           <= 4'd0;
            water_flow_error_led <= 1'b0;
            drainage_error_led   <= 1'b0;
            vibration_error_led  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_chg_temp_d <= change_temperature;
            r_chg_spin_d <= change_spin_speed;

            if (w_hold_next && (r_state != w_next)) r_saved <= r_state;

            // Timer freezes across pause/vibration hold and resumes its count.
            if (w_hold_next || w_resume)  r_timer <= r_timer;
            else if (w_next != r_state)   r_timer <= 8'd0;
            else                          r_timer <= r_timer + 8'd1;

            if (r_state == S_START) begin
                r_temp_idx <= w_temp_rise ? (w_base_temp + 2'd1) : w_base_temp;
                r_spin_lvl <= w_spin_rise ? (w_base_spin + 2'd1) : w_base_spin;
                if (w_temp_rise || w_spin_rise) r_sel_seen <= 1'b1;
                r_mode <= (wash_mode > 3'd3) ? 2'd0 : wash_mode[1:0];
`ifdef EXTRA_RINSE_EN
                r_rinse_pass <= 1'b0;
`endif
            end else begin
                r_sel_seen <= 1'b0;
            end

`ifdef EXTRA_RINSE_EN
            if ((r_state == S_DRAIN_RINSE) && (w_next == S_FILL_RINSE))
                r_rinse_pass <= 1'b1;
`endif

            cycle_complete_led <= (w_next == S_COMPLETE);
            door_lock          <= ((w_next >= S_FILL_INITIAL) && (w_next <= S_SPIN)) ||
                                  (w_next == S_PAUSED) || (w_next == S_VIB_HOLD) ||
                                  (w_next == S_ERROR);
            water_valve        <= (w_next == S_FILL_INITIAL) || (w_next == S_FILL_RINSE);
            heater             <= (w_next == S_HEAT) && (temperature_adc_sensor < w_sel_temp);
            drain_pump         <= (w_next == S_DRAIN_WASH) || (w_next == S_DRAIN_RINSE) ||
                                  (w_next == S_SPIN);
            if ((w_next == S_WASH) || (w_next == S_RINSE)) drum_motor <= 4'd1;
            else if (w_next == S_SPIN)                     drum_motor <= 4'd8 + {2'b00, r_spin_lvl};
            else                                           drum_motor <= 4'd0;
            vibration_error_led <= (w_next == S_VIB_HOLD);
            // Error LEDs latch on entry to ERROR and clear only on the way out.
            water_flow_error_led <= (w_next == S_ERROR) && (w_flow_err || water_flow_error_led);
            drainage_error_led   <= (w_next == S_ERROR) && (w_drain_err || drainage_error_led);
        end
    end

    assign o_dbg_state = r_state;
    assign o_dbg_timer = r_timer;

endmodule

// File: tb/tb_washer_main_controller.sv
// -----------------------------------------------------------------------------
// tb_washer_main_controller
//
// Directed bench for washer_main_controller: a normal full cycle, a quick cycle
// with selector changes and a vibration hold in SPIN, pause/resume in WASH,
// drain and fill timeouts, stop in RINSE and asynchronous reset mid-WASH.
// Inputs are driven 1 ns after each rising edge; outputs are sampled at the
// same point, after the registered outputs have settled.
// -----------------------------------------------------------------------------
module tb_washer_main_controller;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_START = 4'd1, ST_FILL_INITIAL = 4'd2,
                           ST_HEAT = 4'd3, ST_WASH = 4'd4, ST_DRAIN_WASH = 4'd5,
                           ST_FILL_RINSE = 4'd6, ST_RINSE = 4'd7, ST_DRAIN_RINSE = 4'd8,
                           ST_SPIN = 4'd9, ST_COMPLETE = 4'd10, ST_PAUSED = 4'd11,
                           ST_VIB_HOLD = 4'd12, ST_ERROR = 4'd13;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, pause, continue_signal, door_locked, clothes_loaded;
    logic [7:0] load_weight;
    logic       vibration_sensor;
    logic [6:0] temperature_adc_sensor;
    logic [2:0] wash_mode;
    logic       confirm_wash_mode, change_temperature, change_spin_speed;
    logic [9:0] water_level_sensor;
    logic       cycle_complete_led, door_lock, water_valve, heater, drain_pump;
    logic [3:0] drum_motor;
    logic       water_flow_error_led, drainage_error_led, vibration_error_led;
    logic [3:0] dbg_state;
    logic [7:0] dbg_timer;
    logic [11:0] outs;

    int n_checks = 0;
    int n_errs   = 0;

    washer_main_controller dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .stop                   (stop),
        .pause                  (pause),
        .continue_signal        (continue_signal),
        .door_locked            (door_locked),
        .clothes_loaded         (clothes_loaded),
        .load_weight            (load_weight),
        .vibration_sensor       (vibration_sensor),
        .temperature_adc_sensor (temperature_adc_sensor),
        .wash_mode              (wash_mode),
        .confirm_wash_mode      (confirm_wash_mode),
        .change_temperature     (change_temperature),
        .change_spin_speed      (change_spin_speed),
        .water_level_sensor     (water_level_sensor),
        .cycle_complete_led     (cycle_complete_led),
        .door_lock              (door_lock),
        .water_valve            (water_valve),
        .heater                 (heater),
        .drain_pump             (drain_pump),
        .drum_motor             (drum_motor),
        .water_flow_error_led   (water_flow_error_led),
        .drainage_error_led     (drainage_error_led),
        .vibration_error_led    (vibration_error_led),
        .o_dbg_state            (dbg_state),
        .o_dbg_timer            (dbg_timer)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    assign outs = {cycle_complete_led, door_lock, water_valve, heater, drain_pump,
                   drum_motor, water_flow_error_led, drainage_error_led, vibration_error_led};

    // Expected output vector, same field order as outs.
    function automatic logic [11:0] ov(input logic cl, input logic dl, input logic wv,
                                       input logic ht, input logic dp, input logic [3:0] dm,
                                       input logic wf, input logic de, input logic ve);
        ov = {cl, dl, wv, ht, dp, dm, wf, de, ve};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // From IDLE with mode 0, weight 50: START, FILL_INITIAL, HEAT, WASH.
    task automatic run_to_wash(input string tag);
        wash_mode = 3'd0; load_weight = 8'd50; water_level_sensor = 10'd0;
        start = 1'b1; tick(1); start = 1'b0;
        confirm_wash_mode = 1'b1; tick(1); confirm_wash_mode = 1'b0;
        water_level_sensor = 10'd300; tick(1);
        temperature_adc_sensor = 7'd60; tick(1);
        chk({tag, "_in_wash"}, dbg_state, ST_WASH);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; continue_signal = 1'b0;
        door_locked = 1'b0; clothes_loaded = 1'b0; load_weight = 8'd50;
        vibration_sensor = 1'b0; temperature_adc_sensor = 7'd25; wash_mode = 3'd0;
        confirm_wash_mode = 1'b0; change_temperature = 1'b0; change_spin_speed = 1'b0;
        water_level_sensor = 10'd0;

        tick(2);
        chk("reset_state", dbg_state, ST_IDLE);
        chk("reset_outs", outs, 12'd0);
        chk("reset_timer", dbg_timer, 8'd0);
        reset = 1'b1;
        tick(1);

        // ---- normal mode, weight 50 ----
        start = 1'b1; clothes_loaded = 1'b1; door_locked = 1'b1;
        tick(1); start = 1'b0;
        chk("n_start", dbg_state, ST_START);
        chk("n_start_outs", outs, 12'd0);
        tick(1);
        confirm_wash_mode = 1'b1; tick(1); confirm_wash_mode = 1'b0;
        chk("n_fill", dbg_state, ST_FILL_INITIAL);
        chk("n_fill_outs", outs, ov(0, 1, 1, 0, 0, 4'd0, 0, 0, 0));
        water_level_sensor = 10'd299; tick(1);
        chk("n_fill_299", dbg_state, ST_FILL_INITIAL);
        water_level_sensor = 10'd300; tick(1);
        chk("n_heat", dbg_state, ST_HEAT);
        chk("n_heat_outs", outs, ov(0, 1, 0, 1, 0, 4'd0, 0, 0, 0));
        temperature_adc_sensor = 7'd39; tick(1);
        chk("n_heat_39", dbg_state, ST_HEAT);
        chk("n_heater_39", heater, 1'b1);
        temperature_adc_sensor = 7'd40; tick(1);
        chk("n_wash", dbg_state, ST_WASH);
        chk("n_wash_outs", outs, ov(0, 1, 0, 0, 0, 4'd1, 0, 0, 0));
        tick(19);
        chk("n_wash_19", dbg_state, ST_WASH);
        chk("n_wash_t19", dbg_timer, 8'd19);
        tick(1);
        chk("n_drain_wash", dbg_state, ST_DRAIN_WASH);
        chk("n_drain_outs", outs, ov(0, 1, 0, 0, 1, 4'd0, 0, 0, 0));
        water_level_sensor = 10'd16; tick(1);
        chk("n_drain_16", dbg_state, ST_DRAIN_WASH);
        water_level_sensor = 10'd0; tick(1);
        chk("n_fill_rinse", dbg_state, ST_FILL_RINSE);
        chk("n_fill_rinse_valve", water_valve, 1'b1);
        water_level_sensor = 10'd300; tick(1);
        chk("n_rinse", dbg_state, ST_RINSE);
        chk("n_rinse_motor", drum_motor, 4'd1);
        tick(9);
        chk("n_rinse_9", dbg_state, ST_RINSE);
        tick(1);
        chk("n_drain_rinse", dbg_state, ST_DRAIN_RINSE);
        water_level_sensor = 10'd0; tick(1);
        chk("n_spin", dbg_state, ST_SPIN);
        chk("n_spin_outs", outs, ov(0, 1, 0, 0, 1, 4'd10, 0, 0, 0));
        tick(9);
        chk("n_spin_9", dbg_state, ST_SPIN);
        tick(1);
        chk("n_complete", dbg_state, ST_COMPLETE);
        chk("n_complete_outs", outs, ov(1, 0, 0, 0, 0, 4'd0, 0, 0, 0));
        door_locked = 1'b0; tick(1); door_locked = 1'b1;
        chk("n_back_idle", dbg_state, ST_IDLE);
        chk("n_idle_outs", outs, 12'd0);

        // ---- quick mode, weight 100, selector steps, vibration in SPIN ----
        wash_mode = 3'd3; load_weight = 8'd100;
        start = 1'b1; tick(1); start = 1'b0;
        chk("q_start", dbg_state, ST_START);
        tick(1);
        change_spin_speed = 1'b1; tick(1); change_spin_speed = 1'b0; tick(1);
        change_temperature = 1'b1; tick(1); change_temperature = 1'b0; tick(1);
        confirm_wash_mode = 1'b1; tick(1); confirm_wash_mode = 1'b0;
        chk("q_fill", dbg_state, ST_FILL_INITIAL);
        water_level_sensor = 10'd300; tick(1);
        chk("q_fill_300", dbg_state, ST_FILL_INITIAL);
        water_level_sensor = 10'd799; tick(1);
        chk("q_fill_799", dbg_state, ST_FILL_INITIAL);
        water_level_sensor = 10'd800; temperature_adc_sensor = 7'd35; tick(1);
        chk("q_heat", dbg_state, ST_HEAT);
        tick(1);
        chk("q_heat_35", dbg_state, ST_HEAT);
        chk("q_heater_35", heater, 1'b1);
        temperature_adc_sensor = 7'd40; tick(1);
        chk("q_wash", dbg_state, ST_WASH);
        tick(9);
        chk("q_wash_9", dbg_state, ST_WASH);
        tick(1);
        chk("q_drain_wash", dbg_state, ST_DRAIN_WASH);
        water_level_sensor = 10'd0; tick(1);
        water_level_sensor = 10'd800; tick(1);
        chk("q_rinse", dbg_state, ST_RINSE);
        tick(10);
        chk("q_drain_rinse", dbg_state, ST_DRAIN_RINSE);
        water_level_sensor = 10'd0; tick(1);
        chk("q_spin", dbg_state, ST_SPIN);
        chk("q_spin_motor", drum_motor, 4'd11);
        tick(3);
        vibration_sensor = 1'b1; pause = 1'b1; tick(1); pause = 1'b0;
        chk("q_vib_hold", dbg_state, ST_VIB_HOLD);
        chk("q_vib_outs", outs, ov(0, 1, 0, 0, 0, 4'd0, 0, 0, 1));
        continue_signal = 1'b1; tick(1);
        chk("q_vib_ignore", dbg_state, ST_VIB_HOLD);
        chk("q_vib_timer", dbg_timer, 8'd3);
        vibration_sensor = 1'b0; tick(1); continue_signal = 1'b0;
        chk("q_vib_resume", dbg_state, ST_SPIN);
        chk("q_vib_resume_t", dbg_timer, 8'd3);
        chk("q_vib_resume_outs", outs, ov(0, 1, 0, 0, 1, 4'd11, 0, 0, 0));
        tick(6);
        chk("q_spin_rest", dbg_state, ST_SPIN);
        tick(1);
        chk("q_complete", dbg_state, ST_COMPLETE);
        start = 1'b1; tick(1); start = 1'b0;
        chk("q_complete_start", dbg_state, ST_IDLE);

        // ---- pause in WASH, then drain timeout ----
        run_to_wash("p");
        tick(5);
        pause = 1'b1; tick(1); pause = 1'b0;
        chk("p_paused", dbg_state, ST_PAUSED);
        chk("p_paused_outs", outs, ov(0, 1, 0, 0, 0, 4'd0, 0, 0, 0));
        tick(3);
        chk("p_timer_held", dbg_timer, 8'd5);
        continue_signal = 1'b1; tick(1); continue_signal = 1'b0;
        chk("p_resumed", dbg_state, ST_WASH);
        chk("p_resumed_t", dbg_timer, 8'd5);
        chk("p_resumed_motor", drum_motor, 4'd1);
        tick(14);
        chk("p_wash_end", dbg_state, ST_WASH);
        tick(1);
        chk("p_drain", dbg_state, ST_DRAIN_WASH);
        tick(29);
        chk("d_drain_29", dbg_state, ST_DRAIN_WASH);
        tick(1);
        chk("d_error", dbg_state, ST_ERROR);
        chk("d_error_outs", outs, ov(0, 1, 0, 0, 0, 4'd0, 0, 1, 0));
        tick(2);
        chk("d_error_hold", drainage_error_led, 1'b1);
        stop = 1'b1; tick(1); stop = 1'b0;
        chk("d_stop_idle", dbg_state, ST_IDLE);
        chk("d_stop_outs", outs, 12'd0);

        // ---- fill timeout ----
        water_level_sensor = 10'd0;
        start = 1'b1; tick(1); start = 1'b0;
        confirm_wash_mode = 1'b1; tick(1); confirm_wash_mode = 1'b0;
        chk("f_fill", dbg_state, ST_FILL_INITIAL);
        tick(29);
        chk("f_fill_29", dbg_state, ST_FILL_INITIAL);
        tick(1);
        chk("f_error", dbg_state, ST_ERROR);
        chk("f_error_outs", outs, ov(0, 1, 0, 0, 0, 4'd0, 1, 0, 0));
        stop = 1'b1; tick(1); stop = 1'b0;
        chk("f_stop_outs", outs, 12'd0);

        // ---- stop in RINSE ----
        run_to_wash("s");
        tick(20);
        chk("s_drain", dbg_state, ST_DRAIN_WASH);
        water_level_sensor = 10'd0; tick(1);
        water_level_sensor = 10'd300; tick(1);
        chk("s_rinse", dbg_state, ST_RINSE);
        tick(2);
        stop = 1'b1; tick(1); stop = 1'b0;
        chk("s_stop_idle", dbg_state, ST_IDLE);
        chk("s_stop_outs", outs, 12'd0);

        // ---- asynchronous reset mid-WASH ----
        run_to_wash("r");
        tick(3);
        reset = 1'b0; #1;
        chk("r_async_state", dbg_state, ST_IDLE);
        chk("r_async_outs", outs, 12'd0);
        chk("r_async_timer", dbg_timer, 8'd0);
        tick(1);
        reset = 1'b1; tick(1);
        chk("r_after_release", dbg_state, ST_IDLE);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
